// File: rtl/line_buffer_multi.sv
// Multi-line buffer: keeps the last LINES image rows in per-row RAM banks and
// presents one vertically aligned column of LINES+1 taps per accepted pixel.
module line_buffer_multi #(
  parameter int unsigned DATA_W    = 24,
  parameter int unsigned MAX_WIDTH = 2048,
  parameter int unsigned ADDR_W    = 11,
  parameter int unsigned LINES     = 2
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [ADDR_W:0]               img_width,
  input  logic                          valid_i,
  input  logic                          sof_i,
  input  logic [DATA_W-1:0]             data_i,
  output logic                          valid_o,
  output logic [DATA_W*(LINES+1)-1:0]   taps_o,
  output logic                          eol_o
);

  localparam int unsigned    DEPTH = 1 << ADDR_W;
  localparam int unsigned    RW    = $clog2(LINES + 1);
  localparam logic [ADDR_W:0] MAX_W = (ADDR_W+1)'(MAX_WIDTH);
  localparam logic [RW-1:0]  FULL  = RW'(LINES);

  logic [ADDR_W-1:0]            col_q, col_d, col_eff;
  logic [RW-1:0]                rows_q, rows_d, rows_eff;
  logic [ADDR_W:0]              width_q, width_d, width_eff, w_clamp;
  logic                         valid_q, valid_d;
  logic                         eol_q, eol_d;
  logic                         last;
  logic [LINES:0][DATA_W-1:0]   taps_q, taps_d;
  logic [LINES:0][DATA_W-1:0]   rd;

  // rd[k] is the stored column from k rows earlier; rd[0] is the live pixel.
  assign rd[0] = data_i;

  // One bank per stored row. Each accepted pixel pushes the column down one
  // bank: bank g takes the old word of bank g-1 in the same cycle its own
  // old word is read out, giving read-first behaviour for free.
  for (genvar g = 1; g <= LINES; g++) begin : g_bank
    logic [DATA_W-1:0] mem [DEPTH];

    // Column write of the shift-down cascade; RAM contents are never reset.
    always_ff @(posedge clk) begin
      if (valid_i) mem[col_eff] <= rd[g-1];
    end

    assign rd[g] = mem[col_eff];
  end

  // Column/row bookkeeping, width latch and next-output computation.
  always_comb begin
    col_eff  = sof_i ? '0 : col_q;
    rows_eff = sof_i ? '0 : rows_q;

    if (img_width == '0)        w_clamp = (ADDR_W+1)'(1);
    else if (img_width > MAX_W) w_clamp = MAX_W;
    else                        w_clamp = img_width;

    width_eff = (col_eff == '0) ? w_clamp : width_q;
    last      = ({1'b0, col_eff} == width_eff - (ADDR_W+1)'(1));

    col_d   = col_q;
    rows_d  = rows_q;
    width_d = width_q;
    valid_d = 1'b0;
    eol_d   = 1'b0;
    taps_d  = taps_q;

    if (valid_i) begin
      col_d   = last ? '0 : col_eff + ADDR_W'(1);
      rows_d  = (last && rows_eff != FULL) ? rows_eff + RW'(1) : rows_eff;
      width_d = width_eff;
      valid_d = (rows_eff == FULL);
      eol_d   = (rows_eff == FULL) && last;
      taps_d  = rd;
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_q   <= '0;
      rows_q  <= '0;
      width_q <= MAX_W;
      valid_q <= 1'b0;
      eol_q   <= 1'b0;
      taps_q  <= '0;
    end else begin
      col_q   <= col_d;
      rows_q  <= rows_d;
      width_q <= width_d;
      valid_q <= valid_d;
      eol_q   <= eol_d;
      taps_q  <= taps_d;
    end
  end

  assign valid_o = valid_q;
  assign eol_o   = eol_q;
  assign taps_o  = taps_q;

endmodule
